// File: rtl/icache_mshr_alloc_ctrl.sv
// MSHR entry allocator for the icache: tracks FREE/LOOKUP/MISS/REFILL per entry, offers the lowest FREE entry
// with 0-cycle latency from registered state, and issues refills with a held request under dn_req_rdy backpressure.
module icache_mshr_alloc_ctrl #(
    parameter int MSHR_ENTRY_NUM         = 8,
    parameter int MSHR_ENTRY_INDEX_WIDTH = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              alloc_vld,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] alloc_index,
    input  logic                              alloc_rdy,
    input  logic                              lookup_vld,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] lookup_index,
    input  logic                              lookup_hit,
    output logic                              dn_req_vld,
    input  logic                              dn_req_rdy,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] dn_req_index,
    input  logic                              refill_done_vld,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] refill_done_index,
    output logic [MSHR_ENTRY_INDEX_WIDTH:0]   free_cnt,
    output logic                              full,
    output logic                              err
);

    localparam int N  = MSHR_ENTRY_NUM;
    localparam int IW = MSHR_ENTRY_INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } ent_state_t;

    ent_state_t        ent_q [N];
    ent_state_t        ent_d [N];
    logic              dn_lat_vld_q, dn_lat_vld_d;
    logic [IW-1:0]     dn_lat_idx_q, dn_lat_idx_d;
    logic [IW:0]       free_cnt_q, free_cnt_d;
    logic              err_q, err_d;

    logic              any_free, any_miss;
    logic [IW-1:0]     free_idx, miss_idx;
    logic              alloc_fire, dn_fire, lookup_ok, refill_ok;

    // Priority pick: scanning downward leaves the lowest matching index.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        any_miss = 1'b0;
        miss_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (ent_q[i] == ST_MISS) begin
                any_miss = 1'b1;
                miss_idx = IW'(i);
            end
        end
    end

    assign alloc_vld    = any_free;
    assign alloc_index  = free_idx;
    // A stalled request keeps its index even if a lower entry misses meanwhile.
    assign dn_req_vld   = dn_lat_vld_q | any_miss;
    assign dn_req_index = dn_lat_vld_q ? dn_lat_idx_q : miss_idx;

    assign alloc_fire = alloc_vld && alloc_rdy;
    assign dn_fire    = dn_req_vld && dn_req_rdy;
    assign lookup_ok  = lookup_vld && (ent_q[lookup_index] == ST_LOOKUP);
    assign refill_ok  = refill_done_vld && (ent_q[refill_done_index] == ST_REFILL);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (alloc_fire) begin
            ent_d[free_idx] = ST_LOOKUP;
        end
        if (lookup_ok) begin
            ent_d[lookup_index] = lookup_hit ? ST_FREE : ST_MISS;
        end
        if (dn_fire) begin
            ent_d[dn_req_index] = ST_REFILL;
        end
        if (refill_ok) begin
            ent_d[refill_done_index] = ST_FREE;
        end

        dn_lat_vld_d = dn_req_vld && !dn_req_rdy;
        dn_lat_idx_d = dn_req_vld ? dn_req_index : dn_lat_idx_q;

        free_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            if (ent_d[i] == ST_FREE) begin
                free_cnt_d = free_cnt_d + (IW + 1)'(1);
            end
        end

        err_d = err_q
              | (lookup_vld && !lookup_ok)
              | (refill_done_vld && !refill_ok)
              | (alloc_rdy && !alloc_vld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= ST_FREE;
            end
            dn_lat_vld_q <= 1'b0;
            dn_lat_idx_q <= '0;
            free_cnt_q   <= (IW + 1)'(N);
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= ent_d[i];
            end
            dn_lat_vld_q <= dn_lat_vld_d;
            dn_lat_idx_q <= dn_lat_idx_d;
            free_cnt_q   <= free_cnt_d;
            err_q        <= err_d;
        end
    end

    assign free_cnt = free_cnt_q;
    assign full     = (free_cnt_q == '0);
    assign err      = err_q;

endmodule

// File: tb/tb_icache_mshr_alloc_ctrl.sv
// Bench for icache_mshr_alloc_ctrl: directed scenarios plus randomized traffic against a table-level model.
module tb_icache_mshr_alloc_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;
    // Model entry codes
    localparam int FR = 0, LK = 1, MS = 2, RF = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_vld, alloc_rdy;
    logic [IW-1:0] alloc_index;
    logic          lookup_vld, lookup_hit;
    logic [IW-1:0] lookup_index;
    logic          dn_req_vld, dn_req_rdy;
    logic [IW-1:0] dn_req_index;
    logic          refill_done_vld;
    logic [IW-1:0] refill_done_index;
    logic [IW:0]   free_cnt;
    logic          full, err;

    int errors = 0;
    int checks = 0;

    int mst [N];
    int pend;
    bit merr;

    icache_mshr_alloc_ctrl #(.MSHR_ENTRY_NUM(N), .MSHR_ENTRY_INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_index(alloc_index), .alloc_rdy(alloc_rdy),
        .lookup_vld(lookup_vld), .lookup_index(lookup_index), .lookup_hit(lookup_hit),
        .dn_req_vld(dn_req_vld), .dn_req_rdy(dn_req_rdy), .dn_req_index(dn_req_index),
        .refill_done_vld(refill_done_vld), .refill_done_index(refill_done_index),
        .free_cnt(free_cnt), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int m_lowest(int code);
        for (int i = 0; i < N; i++) if (mst[i] == code) return i;
        return -1;
    endfunction

    function automatic int m_count(int code);
        int c = 0;
        for (int i = 0; i < N; i++) if (mst[i] == code) c++;
        return c;
    endfunction

    function automatic int m_dn_idx();
        return (pend >= 0) ? pend : m_lowest(MS);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) mst[i] = FR;
        pend = -1;
        merr = 0;
    endtask

    // Advance the table by one cycle using the inputs currently driven.
    task automatic m_step();
        int nst [N];
        int offer, dnidx;
        offer = m_lowest(FR);
        dnidx = m_dn_idx();
        nst = mst;
        if (alloc_rdy) begin
            if (offer >= 0) nst[offer] = LK; else merr = 1;
        end
        if (lookup_vld) begin
            if (mst[lookup_index] == LK) nst[lookup_index] = lookup_hit ? FR : MS; else merr = 1;
        end
        if (dnidx >= 0 && dn_req_rdy) nst[dnidx] = RF;
        if (refill_done_vld) begin
            if (mst[refill_done_index] == RF) nst[refill_done_index] = FR; else merr = 1;
        end
        pend = (dnidx >= 0 && !dn_req_rdy) ? dnidx : -1;
        mst = nst;
    endtask

    task automatic drive(bit ar, bit lv, int li, bit lh, bit dr, bit rv, int ri);
        alloc_rdy         = ar;
        lookup_vld        = lv;
        lookup_index      = IW'(li);
        lookup_hit        = lh;
        dn_req_rdy        = dr;
        refill_done_vld   = rv;
        refill_done_index = IW'(ri);
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic alloc_n(int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (alloc_vld !== 1'b1) begin errors++; $display("FAIL reset_alloc_vld got %b want 1", alloc_vld); end
        if (alloc_index !== 3'd0) begin errors++; $display("FAIL reset_alloc_index got %0d want 0", alloc_index); end
        if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL reset_dn_req_vld got %b want 0", dn_req_vld); end
        if (dn_req_index !== 3'd0) begin errors++; $display("FAIL reset_dn_req_index got %0d want 0", dn_req_index); end
        if (free_cnt !== 4'd8) begin errors++; $display("FAIL reset_free_cnt got %0d want 8", free_cnt); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_fill();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            checks += 3;
            if (alloc_vld !== 1'b1) begin errors++; $display("FAIL fill_vld step %0d got %b want 1", i, alloc_vld); end
            if (alloc_index !== IW'(i)) begin errors++; $display("FAIL fill_index step %0d got %0d want %0d", i, alloc_index, i); end
            if (free_cnt !== (IW + 1)'(N - i)) begin errors++; $display("FAIL fill_cnt step %0d got %0d want %0d", i, free_cnt, N - i); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 4;
        if (free_cnt !== 4'd0) begin errors++; $display("FAIL fill_final_cnt got %0d want 0", free_cnt); end
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        if (alloc_vld !== 1'b0) begin errors++; $display("FAIL fill_final_vld got %b want 0", alloc_vld); end
        if (err !== 1'b0) begin errors++; $display("FAIL fill_err got %b want 0", err); end
    endtask

    task automatic test_hit();
        do_reset();
        @(negedge clk);
        alloc_n(1);
        checks += 2;
        if (alloc_index !== 3'd1) begin errors++; $display("FAIL hit_pre_index got %0d want 1", alloc_index); end
        if (free_cnt !== 4'd7) begin errors++; $display("FAIL hit_pre_cnt got %0d want 7", free_cnt); end
        drive(0, 1, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 4;
        if (alloc_index !== 3'd0) begin errors++; $display("FAIL hit_index got %0d want 0", alloc_index); end
        if (free_cnt !== 4'd8) begin errors++; $display("FAIL hit_cnt got %0d want 8", free_cnt); end
        if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL hit_dn_vld got %b want 0", dn_req_vld); end
        if (err !== 1'b0) begin errors++; $display("FAIL hit_err got %b want 0", err); end
    endtask

    task automatic test_dn_hold();
        int exp_seq [3] = '{3, 1, 5};
        do_reset();
        @(negedge clk);
        alloc_n(6);
        drive(0, 1, 3, 0, 0, 0, 0); tick();
        checks += 2;
        if (dn_req_vld !== 1'b1) begin errors++; $display("FAIL hold_vld got %b want 1", dn_req_vld); end
        if (dn_req_index !== 3'd3) begin errors++; $display("FAIL hold_first got %0d want 3", dn_req_index); end
        drive(0, 1, 5, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (dn_req_index !== 3'd3) begin errors++; $display("FAIL hold_latched got %0d want 3", dn_req_index); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            checks += 2;
            if (dn_req_vld !== 1'b1) begin errors++; $display("FAIL issue_vld step %0d got %b want 1", k, dn_req_vld); end
            if (dn_req_index !== IW'(exp_seq[k])) begin errors++; $display("FAIL issue_order step %0d got %0d want %0d", k, dn_req_index, exp_seq[k]); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 2;
        if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL issue_done got %b want 0", dn_req_vld); end
        if (err !== 1'b0) begin errors++; $display("FAIL issue_err got %b want 0", err); end
    endtask

    task automatic test_full_err();
        do_reset();
        @(negedge clk);
        alloc_n(8);
        drive(0, 1, 6, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        checks += 2;
        if (full !== 1'b1) begin errors++; $display("FAIL ferr_full got %b want 1", full); end
        if (err !== 1'b0) begin errors++; $display("FAIL ferr_pre_err got %b want 0", err); end
        drive(1, 0, 0, 0, 0, 1, 6); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 4;
        if (err !== 1'b1) begin errors++; $display("FAIL ferr_err got %b want 1", err); end
        if (alloc_vld !== 1'b1) begin errors++; $display("FAIL ferr_vld got %b want 1", alloc_vld); end
        if (alloc_index !== 3'd6) begin errors++; $display("FAIL ferr_index got %0d want 6", alloc_index); end
        if (free_cnt !== 4'd1) begin errors++; $display("FAIL ferr_cnt got %0d want 1", free_cnt); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b want 1", err); end
    endtask

    task automatic test_concurrent();
        do_reset();
        @(negedge clk);
        alloc_n(5);
        drive(0, 1, 2, 1, 0, 0, 0); tick();
        drive(0, 1, 4, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        checks += 2;
        if (free_cnt !== 4'd4) begin errors++; $display("FAIL conc_pre_cnt got %0d want 4", free_cnt); end
        if (alloc_index !== 3'd2) begin errors++; $display("FAIL conc_pre_index got %0d want 2", alloc_index); end
        drive(1, 1, 0, 0, 0, 1, 4); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 5;
        if (free_cnt !== 4'd4) begin errors++; $display("FAIL conc_cnt got %0d want 4", free_cnt); end
        if (alloc_index !== 3'd4) begin errors++; $display("FAIL conc_index got %0d want 4", alloc_index); end
        if (dn_req_vld !== 1'b1) begin errors++; $display("FAIL conc_dn_vld got %b want 1", dn_req_vld); end
        if (dn_req_index !== 3'd0) begin errors++; $display("FAIL conc_dn_index got %0d want 0", dn_req_index); end
        if (err !== 1'b0) begin errors++; $display("FAIL conc_err got %b want 0", err); end
        drive(0, 1, 2, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL conc_lookup_state got err %b want 0", err); end
        if (free_cnt !== 4'd5) begin errors++; $display("FAIL conc_post_cnt got %0d want 5", free_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        alloc_n(4);
        drive(0, 1, 7, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks += 2;
        if (dn_req_vld !== 1'b1) begin errors++; $display("FAIL mid_pre_dn got %b want 1", dn_req_vld); end
        if (err !== 1'b1) begin errors++; $display("FAIL mid_pre_err got %b want 1", err); end
        rst_n = 1'b0;
        m_reset();
        #1;
        checks += 4;
        if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL mid_dn_vld got %b want 0", dn_req_vld); end
        if (free_cnt !== 4'd8) begin errors++; $display("FAIL mid_cnt got %0d want 8", free_cnt); end
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        if (alloc_index !== 3'd0) begin errors++; $display("FAIL mid_index got %0d want 0", alloc_index); end
        #1;
        rst_n = 1'b1;
        checks++;
        if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL mid_release_dn got %b want 0", dn_req_vld); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int q_lk [$];
        int q_rf [$];
        int li, ri, e;
        logic [IW-1:0] ei;
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) begin
                do_reset();
                @(negedge clk);
            end
            q_lk.delete();
            q_rf.delete();
            for (int i = 0; i < N; i++) begin
                if (mst[i] == LK) q_lk.push_back(i);
                if (mst[i] == RF) q_rf.push_back(i);
            end
            li = (q_lk.size() > 0 && $urandom_range(0, 9) != 0) ? q_lk[$urandom_range(0, q_lk.size() - 1)] : int'($urandom_range(0, N - 1));
            ri = (q_rf.size() > 0 && $urandom_range(0, 9) != 0) ? q_rf[$urandom_range(0, q_rf.size() - 1)] : int'($urandom_range(0, N - 1));
            drive($urandom_range(0, 1), $urandom_range(0, 2) != 0, li, $urandom_range(0, 1),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, ri);
            e = m_lowest(FR);
            checks += 5;
            if (alloc_vld !== (e >= 0)) begin errors++; $display("FAIL rnd_alloc_vld cyc %0d got %b want %0d", c, alloc_vld, e >= 0); end
            ei = IW'(e);
            if (e >= 0 && alloc_index !== ei) begin errors++; $display("FAIL rnd_alloc_index cyc %0d got %0d want %0d", c, alloc_index, e); end
            e = m_dn_idx();
            if (dn_req_vld !== (e >= 0)) begin errors++; $display("FAIL rnd_dn_vld cyc %0d got %b want %0d", c, dn_req_vld, e >= 0); end
            ei = IW'(e);
            if (e >= 0 && dn_req_index !== ei) begin errors++; $display("FAIL rnd_dn_index cyc %0d got %0d want %0d", c, dn_req_index, e); end
            if (free_cnt !== (IW + 1)'(m_count(FR)) || full !== (m_count(FR) == 0) || err !== merr) begin
                errors++;
                $display("FAIL rnd_regs cyc %0d got cnt=%0d full=%b err=%b want cnt=%0d full=%0d err=%0d",
                         c, free_cnt, full, err, m_count(FR), m_count(FR) == 0, merr);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        test_reset();
        test_fill();
        test_hit();
        test_dn_hold();
        test_full_err();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_mshr_alloc_ctrl.md
ICACHE_MSHR_ALLOC_CTRL -- requirements
Module: icache_mshr_alloc_ctrl

Interface
REQ-001 SHALL have parameter MSHR_ENTRY_NUM, default 8, number of MSHR entries (power of two, >=2).
REQ-002 SHALL have parameter MSHR_ENTRY_INDEX_WIDTH, default 3, equal to log2(MSHR_ENTRY_NUM).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port alloc_vld  output  1  a FREE entry is offered.
REQ-006 SHALL have port alloc_index  output  MSHR_ENTRY_INDEX_WIDTH  offered entry index.
REQ-007 SHALL have port alloc_rdy  input  1  offered entry is consumed this cycle.
REQ-008 SHALL have port lookup_vld  input  1  tag lookup result for an allocated entry.
REQ-009 SHALL have port lookup_index  input  MSHR_ENTRY_INDEX_WIDTH  entry of the lookup result.
REQ-010 SHALL have port lookup_hit  input  1  1 = hit, 0 = miss.
REQ-011 SHALL have port dn_req_vld  output  1  refill request to downstream.
REQ-012 SHALL have port dn_req_rdy  input  1  downstream accepts refill request.
REQ-013 SHALL have port dn_req_index  output  MSHR_ENTRY_INDEX_WIDTH  entry being issued.
REQ-014 SHALL have port refill_done_vld  input  1  refill for an entry completed.
REQ-015 SHALL have port refill_done_index  input  MSHR_ENTRY_INDEX_WIDTH  completed entry.
REQ-016 SHALL have port free_cnt  output  MSHR_ENTRY_INDEX_WIDTH+1  number of FREE entries.
REQ-017 SHALL have port full  output  1  no FREE entry (free_cnt==0).
REQ-018 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-019 SHALL hold a 2-bit state per entry: FREE, LOOKUP, MISS, REFILL.
REQ-020 FREE->LOOKUP SHALL occur when alloc_vld && alloc_rdy for that entry.
REQ-021 LOOKUP->FREE SHALL occur on lookup_vld && lookup_hit for that entry; LOOKUP->MISS on lookup_vld && !lookup_hit.
REQ-022 MISS->REFILL SHALL occur on dn_req_vld && dn_req_rdy for that entry.
REQ-023 REFILL->FREE SHALL occur on refill_done_vld for that entry.
REQ-024 alloc_vld SHALL be 1 iff any entry is FREE in registered state; alloc_index SHALL be lowest-index FREE entry, combinational from state (0-cycle offer).
REQ-025 An entry freed in cycle N SHALL not be offered before cycle N+1.
REQ-026 dn_req_vld SHALL be 1 iff a MISS entry exists or a latched request is pending; selection is lowest-index MISS entry.
REQ-027 Once dn_req_vld is asserted without dn_req_rdy, dn_req_index SHALL be latched and held stable until handshake, even if a lower-index entry enters MISS.
REQ-028 Lookup, refill_done, alloc and dn handshake on different entries in the same cycle SHALL all take effect.
REQ-029 free_cnt SHALL be registered, equal to the count of FREE entries after the update of each cycle (+freed, -allocated, same-cycle net).
REQ-030 full SHALL equal (free_cnt==0).
REQ-031 lookup_vld on a non-LOOKUP entry, refill_done_vld on a non-REFILL entry, or alloc_rdy while alloc_vld==0 SHALL be ignored for state and SHALL set err to 1 on next edge.
REQ-032 err SHALL remain 1 until reset.

Reset
REQ-033 On rst_n low all entries SHALL go FREE asynchronously, any latched dn request SHALL clear.
REQ-034 Reset values: alloc_vld=1, alloc_index=0, dn_req_vld=0, dn_req_index=0, free_cnt=MSHR_ENTRY_NUM, full=0, err=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; no dn_req_vld before the first edge after deassertion.

Verification
REQ-036 After reset, alloc_rdy=1 for 8 cycles -> alloc_index 0..7 in order, free_cnt 8->0, full=1 in cycle 9, alloc_vld=0.
REQ-037 Alloc entry 0, lookup_vld hit index 0 -> entry 0 FREE next cycle, alloc_index=0 again, free_cnt restored, dn_req_vld stays 0.
REQ-038 Entries 3 and 5 miss, dn_req_rdy=0 -> dn_req_index=3 held; entry 1 misses later -> index still 3; rdy=1 -> issues 3, then 1, then 5.
REQ-039 Full table, refill_done for 6 and alloc_rdy same cycle -> err=1 (alloc_rdy with alloc_vld=0), next cycle alloc_vld=1, alloc_index=6, free_cnt=1.
REQ-040 Same cycle: alloc entry 2, lookup miss entry 0, refill_done entry 4 -> states LOOKUP/MISS/FREE respectively, free_cnt net 0 change.
REQ-041 rst_n pulled low while dn_req_vld=1 and 4 entries busy -> immediately dn_req_vld=0, free_cnt=8, err=0.
